// File: rtl/ysyx_fetch_ctrl_if.sv
// rtl/ysyx_fetch_ctrl_if.sv - instruction-memory request/response bundle for ysyx_fetch_ctrl
interface ysyx_fetch_ctrl_if;
   logic        ifu_req_valid;
   logic [31:0] ifu_req_addr;
   logic        ifu_req_ready;
   logic        ifu_rsp_valid;
   logic [31:0] ifu_rsp_inst;
   logic        ifu_rsp_err;

   modport master (
      output ifu_req_valid,
      output ifu_req_addr,
      input  ifu_req_ready,
      input  ifu_rsp_valid,
      input  ifu_rsp_inst,
      input  ifu_rsp_err
   );

   modport slave (
      input  ifu_req_valid,
      input  ifu_req_addr,
      output ifu_req_ready,
      output ifu_rsp_valid,
      output ifu_rsp_inst,
      output ifu_rsp_err
   );
endinterface

// File: rtl/ysyx_fetch_ctrl.sv
// rtl/ysyx_fetch_ctrl.sv - multi-cycle fetch sequencer owning the PC (optional perf counters: YSYX_FETCH_PERF_EN)
module ysyx_fetch_ctrl #(
   parameter logic [31:0] RESET_PC     = 32'h80000000,
   parameter int unsigned WAIT_TIMEOUT = 0
) (
   input  logic               clk,
   input  logic               rst,
   ysyx_fetch_ctrl_if.master  ifu,
   output logic [31:0]        inst,
   output logic               inst_valid,
   input  logic               exe_done,
   input  logic               jump,
   input  logic [31:0]        jump_addr,
   input  logic               is_ecall,
   input  logic [31:0]        mtvecdata,
   input  logic               is_mret,
   input  logic [31:0]        mepcdata,
   output logic [31:0]        pc,
   output logic               fetch_err
`ifdef YSYX_FETCH_PERF_EN
   ,
   output logic [31:0]        perf_retired,
   output logic [31:0]        perf_stall
`endif
);

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_EXEC = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] next_pc;

   // State, PC, instruction and WAIT-cycle counter registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_REQ;
         pc_q    <= RESET_PC;
         inst_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         cnt_q   <= cnt_d;
      end
   end

   // Fixed-priority redirect select; target low bits pass through untouched
   always_comb begin
      next_pc = pc_q + 32'd4;
      if (jump)          next_pc = jump_addr;
      else if (is_ecall) next_pc = mtvecdata;
      else if (is_mret)  next_pc = mepcdata;
   end

   // Next-state logic; the counter defaults to zero so it clears whenever WAIT is left
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      cnt_d   = '0;
      unique case (state_q)
         ST_REQ: begin
            if (ifu.ifu_req_ready) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (ifu.ifu_rsp_valid) begin
               if (ifu.ifu_rsp_err) begin
                  state_d = ST_ERR;
               end else begin
                  inst_d  = ifu.ifu_rsp_inst;
                  state_d = ST_EXEC;
               end
            end else if (WAIT_TIMEOUT != 0 && cnt_q == 32'(WAIT_TIMEOUT) - 32'd1) begin
               state_d = ST_ERR;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         ST_EXEC: begin
            if (exe_done) begin
               pc_d    = next_pc;
               state_d = ST_REQ;
            end
         end
         default: begin
            // ERR holds everything until reset
         end
      endcase
   end

   assign ifu.ifu_req_valid = (state_q == ST_REQ);
   assign ifu.ifu_req_addr  = pc_q;
   assign inst              = inst_q;
   assign inst_valid        = (state_q == ST_EXEC);
   assign pc                = pc_q;
   assign fetch_err         = (state_q == ST_ERR);

`ifdef YSYX_FETCH_PERF_EN
   logic [31:0] retired_q, stall_q;

   // Retire and stall counters; ERR matches neither condition so they freeze there
   always_ff @(posedge clk) begin
      if (!rst) begin
         retired_q <= '0;
         stall_q   <= '0;
      end else begin
         if (state_q == ST_EXEC && exe_done) retired_q <= retired_q + 32'd1;
         if ((state_q == ST_REQ && !ifu.ifu_req_ready) || state_q == ST_WAIT)
            stall_q <= stall_q + 32'd1;
      end
   end

   assign perf_retired = retired_q;
   assign perf_stall   = stall_q;
`endif

endmodule

// File: tb/tb_ysyx_fetch_ctrl.sv
// tb/tb_ysyx_fetch_ctrl.sv - directed vector bench for ysyx_fetch_ctrl
module tb_ysyx_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] inst;
   logic        inst_valid;
   logic        exe_done;
   logic        jump;
   logic [31:0] jump_addr;
   logic        is_ecall;
   logic [31:0] mtvecdata;
   logic        is_mret;
   logic [31:0] mepcdata;
   logic [31:0] pc;
   logic        fetch_err;
`ifdef YSYX_FETCH_PERF_EN
   logic [31:0] perf_retired;
   logic [31:0] perf_stall;
`endif

   int total = 0;
   int bad   = 0;

   ysyx_fetch_ctrl_if bus();

   ysyx_fetch_ctrl #(
      .RESET_PC     (32'h80000000),
      .WAIT_TIMEOUT (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ifu        (bus.master),
      .inst       (inst),
      .inst_valid (inst_valid),
      .exe_done   (exe_done),
      .jump       (jump),
      .jump_addr  (jump_addr),
      .is_ecall   (is_ecall),
      .mtvecdata  (mtvecdata),
      .is_mret    (is_mret),
      .mepcdata   (mepcdata),
      .pc         (pc),
      .fetch_err  (fetch_err)
`ifdef YSYX_FETCH_PERF_EN
      ,
      .perf_retired (perf_retired),
      .perf_stall   (perf_stall)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        jmp;
      logic [31:0] jaddr;
      logic        ec;
      logic [31:0] mtvec;
      logic        mr;
      logic [31:0] mepc;
      logic [31:0] inst_w;
      int          hold;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t vecs[8];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic clear_redirects();
      exe_done  = 1'b0;
      jump      = 1'b0;
      jump_addr = '0;
      is_ecall  = 1'b0;
      mtvecdata = '0;
      is_mret   = 1'b0;
      mepcdata  = '0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
   endtask

   logic [31:0] cur_pc;

   initial begin
      vecs[0] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h00000013, 0, 32'h80000004};
      vecs[1] = '{1'b1, 32'h80000100, 1'b1, 32'h80000200, 1'b1, 32'h80000300, 32'h00100093, 2, 32'h80000100};
      vecs[2] = '{1'b0, 32'h0,        1'b1, 32'h80000200, 1'b1, 32'h80000300, 32'h00000073, 0, 32'h80000200};
      vecs[3] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h80000300, 32'h30200073, 1, 32'h80000300};
      vecs[4] = '{1'b1, 32'hFFFFFFFC, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000006F, 0, 32'hFFFFFFFC};
      vecs[5] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h00000013, 0, 32'h00000000};
      vecs[6] = '{1'b1, 32'h80000002, 1'b0, 32'h0,        1'b1, 32'h80000300, 32'h12345678, 0, 32'h80000002};
      vecs[7] = '{1'b0, 32'h0,        1'b1, 32'h80001000, 1'b0, 32'h0,        32'hDEADBEEF, 0, 32'h80001000};

      bus.ifu_req_ready = 1'b0;
      bus.ifu_rsp_valid = 1'b0;
      bus.ifu_rsp_inst  = '0;
      bus.ifu_rsp_err   = 1'b0;
      clear_redirects();

      // Reset state
      rst = 1'b0;
      step();
      step();
      check("rst_pc", pc, 32'h80000000);
      check("rst_req_valid", {31'd0, bus.ifu_req_valid}, 32'd1);
      check("rst_inst", inst, 32'h0);
      check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
      check("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
      rst = 1'b1;

      // Back-pressure: request must hold steady while ready is low
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_req_valid", {31'd0, bus.ifu_req_valid}, 32'd1);
         check("bp_req_addr", bus.ifu_req_addr, 32'h80000000);
      end
`ifdef YSYX_FETCH_PERF_EN
      check("bp_perf_stall", perf_stall, 32'd5);
`endif

      // Table-driven full fetch/execute cycles
      cur_pc = 32'h80000000;
      for (int i = 0; i < 8; i++) begin
         check("v_req_valid", {31'd0, bus.ifu_req_valid}, 32'd1);
         check("v_req_addr", bus.ifu_req_addr, cur_pc);
         bus.ifu_req_ready = 1'b1;
         step();
         bus.ifu_req_ready = 1'b0;
         check("v_wait_req_valid", {31'd0, bus.ifu_req_valid}, 32'd0);
         check("v_wait_inst_valid", {31'd0, inst_valid}, 32'd0);
         bus.ifu_rsp_valid = 1'b1;
         bus.ifu_rsp_inst  = vecs[i].inst_w;
         step();
         bus.ifu_rsp_valid = 1'b0;
         bus.ifu_rsp_inst  = '0;
         check("v_inst_valid", {31'd0, inst_valid}, 32'd1);
         check("v_inst", inst, vecs[i].inst_w);
         jump      = vecs[i].jmp;
         jump_addr = vecs[i].jaddr;
         is_ecall  = vecs[i].ec;
         mtvecdata = vecs[i].mtvec;
         is_mret   = vecs[i].mr;
         mepcdata  = vecs[i].mepc;
         for (int h = 0; h < vecs[i].hold; h++) begin
            step();
            check("v_hold_inst_valid", {31'd0, inst_valid}, 32'd1);
            check("v_hold_inst", inst, vecs[i].inst_w);
            check("v_hold_pc", pc, cur_pc);
         end
         exe_done = 1'b1;
         step();
         clear_redirects();
         check("v_next_pc", pc, vecs[i].exp_pc);
         check("v_post_inst_valid", {31'd0, inst_valid}, 32'd0);
         check("v_post_req_valid", {31'd0, bus.ifu_req_valid}, 32'd1);
         check("v_post_req_addr", bus.ifu_req_addr, vecs[i].exp_pc);
         cur_pc = vecs[i].exp_pc;
      end
`ifdef YSYX_FETCH_PERF_EN
      check("perf_retired", perf_retired, 32'd8);
`endif

      // exe_done outside EXEC is ignored (REQ then WAIT)
      exe_done  = 1'b1;
      jump      = 1'b1;
      jump_addr = 32'h12345678;
      step();
      check("oob_req_pc", pc, cur_pc);
      check("oob_req_valid", {31'd0, bus.ifu_req_valid}, 32'd1);
      bus.ifu_req_ready = 1'b1;
      step();
      bus.ifu_req_ready = 1'b0;
      step();
      check("oob_wait_pc", pc, cur_pc);
      check("oob_wait_req_valid", {31'd0, bus.ifu_req_valid}, 32'd0);
      clear_redirects();

      // Reset while in WAIT, then a stale response arrives
      rst = 1'b0;
      step();
      rst = 1'b1;
      bus.ifu_rsp_valid = 1'b1;
      bus.ifu_rsp_inst  = 32'hCAFEF00D;
      for (int i = 0; i < 2; i++) begin
         step();
         check("midwait_pc", pc, 32'h80000000);
         check("midwait_req_valid", {31'd0, bus.ifu_req_valid}, 32'd1);
         check("midwait_inst", inst, 32'h0);
         check("midwait_inst_valid", {31'd0, inst_valid}, 32'd0);
         check("midwait_fetch_err", {31'd0, fetch_err}, 32'd0);
      end
      bus.ifu_rsp_valid = 1'b0;
      bus.ifu_rsp_inst  = '0;

      // Timeout: 4 silent WAIT cycles raise fetch_err
      bus.ifu_req_ready = 1'b1;
      step();
      bus.ifu_req_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("to_early_fetch_err", {31'd0, fetch_err}, 32'd0);
      end
      step();
      check("to_fetch_err", {31'd0, fetch_err}, 32'd1);
      check("to_req_valid", {31'd0, bus.ifu_req_valid}, 32'd0);
      check("to_inst_valid", {31'd0, inst_valid}, 32'd0);

      // Bus error response: terminal, exe_done ignored, pc frozen
      do_reset();
      bus.ifu_req_ready = 1'b1;
      step();
      bus.ifu_req_ready = 1'b0;
      bus.ifu_rsp_valid = 1'b1;
      bus.ifu_rsp_err   = 1'b1;
      bus.ifu_rsp_inst  = 32'h00000013;
      step();
      bus.ifu_rsp_valid = 1'b0;
      bus.ifu_rsp_err   = 1'b0;
      check("err_fetch_err", {31'd0, fetch_err}, 32'd1);
      check("err_inst", inst, 32'h0);
      exe_done          = 1'b1;
      jump              = 1'b1;
      jump_addr         = 32'h80000100;
      bus.ifu_req_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("err_hold_fetch_err", {31'd0, fetch_err}, 32'd1);
         check("err_hold_req_valid", {31'd0, bus.ifu_req_valid}, 32'd0);
         check("err_hold_inst_valid", {31'd0, inst_valid}, 32'd0);
         check("err_hold_pc", pc, 32'h80000000);
      end
      clear_redirects();
      bus.ifu_req_ready = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
